// File: rtl/l1_pkg.sv
// l1_pkg: command encodings and replay FSM state type shared by the trace player
package l1_pkg;
    localparam logic [1:0] CMD_RD  = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_IF  = 2'd2;
    localparam logic [1:0] CMD_NOP = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;
endpackage

// File: rtl/l1_trace_mem.sv
// l1_trace_mem: DEPTH x W entry store, synchronous write port, asynchronous read port
module l1_trace_mem
    import l1_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 66,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic [AW-1:0] ra_i,
    output logic [W-1:0]  rd_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) if (we_i) mem_q[wa_i] <= wd_i;
    assign rd_o = mem_q[ra_i];
endmodule

// File: rtl/l1_trace_player.sv
// l1_trace_player: loads a trace of cache requests, then replays it onto an L1 request port
// ports: ld_* load handshake; start/loop_en/abort/clear/stall replay control;
//        L1cmd/L1addr/L1data/L1valid request bus; busy/done/issued_cnt status
module l1_trace_player
    import l1_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CMD_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [CMD_W-1:0]  ld_cmd,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic              loop_en,
    input  logic              abort,
    input  logic              clear,
    input  logic              stall,
    output logic [CMD_W-1:0]  L1cmd,
    output logic [ADDR_W-1:0] L1addr,
    inout  wire  [DATA_W-1:0] L1data,
    output logic              L1valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       issued_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = CMD_W + ADDR_W + DATA_W;
    state_t state_q, state_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] iss_q, iss_d;
    logic init_q;
    logic [EW-1:0] ent;
    logic issue, ld_fire, accept, last, can_start;
    l1_trace_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
        .clk  (clk),
        .we_i (ld_fire),
        .wa_i (wr_q),
        .wd_i ({ld_cmd, ld_addr, ld_data}),
        .ra_i (rd_q),
        .rd_o (ent)
    );
    assign issue      = state_q == ST_ISSUE;
    // init_q keeps ld_ready low until the first edge after reset release
    assign ld_ready   = init_q && state_q == ST_IDLE && cnt_q != CW'(DEPTH);
    assign ld_fire    = ld_valid && ld_ready && !clear;
    assign accept     = issue && !abort && !stall;
    assign last       = {1'b0, rd_q} == cnt_q - CW'(1);
    assign can_start  = start && cnt_q != '0;
    assign L1valid    = issue;
    assign busy       = issue;
    assign done       = state_q == ST_DONE;
    assign L1cmd      = issue ? ent[EW-1 -: CMD_W] : CMD_W'(CMD_NOP);
    assign L1addr     = issue ? ent[DATA_W +: ADDR_W] : '0;
    assign L1data     = (issue && L1cmd == CMD_W'(CMD_WR)) ? ent[DATA_W-1:0] : {DATA_W{1'bz}};
    assign issued_cnt = iss_q;
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        iss_d   = iss_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    wr_d  = '0;
                    cnt_d = '0;
                end else begin
                    if (ld_fire) begin
                        wr_d  = wr_q + PW'(1);
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (can_start) begin
                        rd_d    = '0;
                        iss_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) state_d = ST_IDLE;
                else if (accept) begin
                    rd_d  = last ? '0 : rd_q + PW'(1);
                    iss_d = iss_q + {15'd0, iss_q != 16'hFFFF};
                    if (last && !loop_en) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clear || abort) state_d = ST_IDLE;
                else if (can_start) begin
                    rd_d    = '0;
                    iss_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            iss_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            iss_q   <= iss_d;
            init_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l1_trace_player.sv
// tb_l1_trace_player: directed replay scenarios with hand-computed expectations
module tb_l1_trace_player;
    logic clk = 0, rst_n = 0, ld_valid = 0, start = 0, loop_en = 0, abort = 0, clear = 0, stall = 0;
    logic [1:0] ld_cmd = 0;
    logic [31:0] ld_addr = 0, ld_data = 0;
    logic ld_ready, L1valid, busy, done;
    logic [1:0] L1cmd;
    logic [31:0] L1addr;
    logic [15:0] issued_cnt;
    wire [31:0] L1data;
    int vec = 0, errs = 0;
    // the pullup makes a released (high-Z) bus read back as all ones
    localparam logic [31:0] PZ = 32'hFFFF_FFFF;
    pullup (L1data);
    always #5 clk = ~clk;
    l1_trace_player dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_cmd(ld_cmd), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .loop_en(loop_en), .abort(abort), .clear(clear), .stall(stall),
        .L1cmd(L1cmd), .L1addr(L1addr), .L1data(L1data), .L1valid(L1valid),
        .busy(busy), .done(done), .issued_cnt(issued_cnt)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic load(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        ld_valid = 1; ld_cmd = c; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 0;
    endtask
    task automatic pulse_start;
        start = 1;
        tick();
        start = 0;
    endtask
    task automatic req(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, L1valid, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cmd"}, L1cmd, c);
        chk({tag, "_addr"}, L1addr, a);
        chk({tag, "_data"}, L1data, d);
    endtask
    task automatic idle_bus(input string tag);
        chk({tag, "_valid"}, L1valid, 0);
        chk({tag, "_cmd"}, L1cmd, 3);
        chk({tag, "_addr"}, L1addr, 0);
        chk({tag, "_data"}, L1data, PZ);
    endtask
    initial begin
        #3;
        idle_bus("rst");
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ldrdy", ld_ready, 0);
        chk("rst_iss", issued_cnt, 0);
        #9 rst_n = 1;
        #1 chk("rel_ldrdy_pre", ld_ready, 0);
        tick();
        chk("rel_ldrdy", ld_ready, 1);
        // three-entry trace, no stall
        load(0, 32'h100, 0);
        load(1, 32'h104, 32'hDEAD);
        load(2, 32'h200, 0);
        pulse_start();
        req("t1_e0", 0, 32'h100, PZ);
        chk("t1_ldrdy", ld_ready, 0);
        chk("t1_iss0", issued_cnt, 0);
        tick();
        req("t1_e1", 1, 32'h104, 32'hDEAD);
        tick();
        req("t1_e2", 2, 32'h200, PZ);
        tick();
        idle_bus("t1_done");
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_iss", issued_cnt, 3);
        chk("t1_done_ldrdy", ld_ready, 0);
        // replay from DONE with a 4-cycle stall on entry 1
        pulse_start();
        req("t2_e0", 0, 32'h100, PZ);
        tick();
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            req($sformatf("t2_stall%0d", i), 1, 32'h104, 32'hDEAD);
            chk($sformatf("t2_stall_iss%0d", i), issued_cnt, 1);
            tick();
        end
        stall = 0;
        req("t2_e1_rel", 1, 32'h104, 32'hDEAD);
        tick();
        req("t2_e2", 2, 32'h200, PZ);
        tick();
        chk("t2_done", done, 1);
        chk("t2_iss", issued_cnt, 3);
        abort = 1;
        tick();
        abort = 0;
        chk("t2_abort_done", done, 0);
        chk("t2_abort_ldrdy", ld_ready, 1);
        // clear beats a same-cycle load; start on the empty buffer is ignored
        clear = 1; ld_valid = 1; ld_addr = 32'h300;
        tick();
        clear = 0; ld_valid = 0;
        pulse_start();
        idle_bus("t3_empty");
        chk("t3_busy", busy, 0);
        chk("t3_done", done, 0);
        chk("t3_ldrdy", ld_ready, 1);
        // fill to DEPTH; a 17th offer must be refused
        for (int i = 0; i < 16; i++) load(i == 5 ? 2'd1 : 2'd0, 32'h1000 + 32'(4 * i), 32'hBEEF);
        chk("t4_full_ldrdy", ld_ready, 0);
        ld_valid = 1; ld_addr = 32'hFFF0;
        tick();
        chk("t4_17_ldrdy", ld_ready, 0);
        ld_valid = 0;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            req($sformatf("t4_e%0d", i), i == 5 ? 2'd1 : 2'd0, 32'h1000 + 32'(4 * i), i == 5 ? 32'hBEEF : PZ);
            tick();
        end
        chk("t4_done", done, 1);
        chk("t4_iss", issued_cnt, 16);
        // looping replay of two entries, then abort
        clear = 1;
        tick();
        tick();
        clear = 0;
        load(0, 32'h40, 0);
        load(2, 32'h44, 0);
        loop_en = 1;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t5_addr%0d", k), L1addr, (k % 2) ? 32'h44 : 32'h40);
            tick();
        end
        chk("t5_iss", issued_cnt, 7);
        abort = 1;
        tick();
        abort = 0; loop_en = 0;
        idle_bus("t5_abort");
        chk("t5_abort_ldrdy", ld_ready, 1);
        pulse_start();
        req("t5_r0", 0, 32'h40, PZ);
        tick();
        req("t5_r1", 2, 32'h44, PZ);
        tick();
        chk("t5_done", done, 1);
        chk("t5_iss2", issued_cnt, 2);
        // asynchronous reset in the middle of a write request
        clear = 1;
        tick();
        tick();
        clear = 0;
        load(1, 32'h80, 32'h1234);
        pulse_start();
        req("t6_wr", 1, 32'h80, 32'h1234);
        rst_n = 0;
        #1;
        idle_bus("t6_rst");
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ldrdy", ld_ready, 0);
        chk("t6_rst_iss", issued_cnt, 0);
        #3 rst_n = 1;
        tick();
        chk("t6_rel_ldrdy", ld_ready, 1);
        pulse_start();
        idle_bus("t6_nostart");
        chk("t6_nostart_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
